hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Producer side of the EX-stage operand-forwarding interface. Generates rs_fwd, rt_fwd, ld_rs_fwd and ld_rt_fwd for the instruction entering EX, and the stall for IF/ID.
- Keeps its own shadow of the EX and MEM pipeline slots (dest register, opcode, valid). Compares each decoded instruction's sources against in-flight writers.
- Sits beside the ID stage. Its forwarding outputs are registered so they arrive in EX on the same edge as the instruction.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID slot holds a real instruction (0 = bubble).
- id_opcode  in  6  opcode of the instruction in ID (`def.v` encoding).
- id_rs  in  5  rs source register.
- id_rt  in  5  rt source register (store data for `SDW).
- id_rwd  in  5  destination register.
- rs_fwd  out  3  to EX: 0 = regfile, 1 = EX's own previous alu result, 2 = alu_out_from_mem.
- rt_fwd  out  3  same encoding for the b operand.
- ld_rs_fwd  out  3  to EX: 2 = mem_data_from_mem, else 0.
- ld_rt_fwd  out  3  same for the b operand.
- stall  out  1  combinational. Hold PC and IF/ID this cycle, and inject a bubble into EX.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles since reset.

Behaviour:
- Writer predicate wr(op,rwd,vld): vld && rwd != 0 && op != `SDW && op != `NOP.
- Shadow regs: ex_{op,rwd,vld} (age 1) and mem_{op,rwd,vld} (age 2).
- Shadow update, every posedge:
  - mem <= ex.
  - If stall, ex <= bubble (vld = 0). Otherwise ex <= {id_opcode, id_rwd, id_valid}.
- Register 0 never matches.
- The regfile writes in WB and is readable by ID in the same cycle (write-through). Age 3 and older therefore needs no action.
- Memory-class instructions (`LDW, `SDW): EX uses imm as operand b, and any nonzero rt_fwd overrides imm. For these, rt_fwd and ld_rt_fwd are forced to 0.
- rs source, per ID instruction; first matching rule wins:
  - a1 = age-1 writer match.
  - If a1 and ex_op == `LDW: stall.
  - Else if a1: code 1.
  - Else if age-2 writer match and mem_op == `LDW: ld code 2.
  - Else if age-2 writer match: code 2.
  - Else 0.
- rt source: same rules as rs for non-memory instructions.
- `SDW store data (id_rt): EX does not forward it. If id_rt matches an age-1 or age-2 writer, stall.
  - Matching age 1 gives 2 stall cycles; matching age 2 gives 1.
  - This follows naturally because stall is re-evaluated every cycle as the writer ages.
- stall = OR of all stall conditions, gated by id_valid.
- Forwarding registers:
  - On each posedge they load the codes computed for ID.
  - If stall, they load all zeros (a bubble has no hazards).
  - Reset value of every forwarding output is 0.
- Age preference: the youngest producer always wins. Age-1 ALU beats age-2 anything, and a load at age 2 yields rs_fwd = 0, ld_rs_fwd = 2. This matches EX priority.
- stall_count: increments on each posedge with stall = 1 and saturates at all-ones. Reset value is 0.
- Reset (any time, including mid-stall):
  - All shadow valids = 0, fwd outputs = 0, stall_count = 0.
  - stall deasserts combinationally because the shadow is empty.
- Same register in rs and rt: both codes are set independently.
- Load writing r0: never stalls.

Decomposition:
- def.v gains `FWD_NONE = 0, `FWD_EX = 1, `FWD_MEM = 2 and `LDFWD_MEM = 2, shared with EX.
- def.v gains `NOP if it is not already present.
- One sub-module, hazard_src_check: takes one source register, the two shadow slots and an is_store_data flag. Outputs {fwd_code, ld_code, stall_req}. It is instantiated for rs and for rt.

Test Plan:
- add r3 then add r4,r3,r1 on back-to-back cycles: second instruction enters EX with rs_fwd = 1, all others 0, stall never high.
- add r3, nop, sub r5,r3,r3: sub enters EX with rs_fwd = 2 and rt_fwd = 2.
- ldw r2 then add r6,r2,r7:
  - stall = 1 for exactly one cycle and a bubble enters EX (all codes 0).
  - add then enters EX with rs_fwd = 0, ld_rs_fwd = 2.
  - stall_count = 1.
- add r9 then sdw r9 (store data), with base r1 unrelated: stall high for exactly 2 cycles. sdw enters EX with rt_fwd = 0, ld_rt_fwd = 0, and stall_count = 2.
- Writers to r0, and ldw r0 followed by use of r0: no stall, all codes 0. ldw r8 with id_valid = 0 on the consumer: no stall.
- Assert rst during the load-use stall: outputs zero immediately, stall = 0. After release, stall_count counts from 0 and saturates at 65535 under a forced 70000-cycle stall.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared opcode, forwarding-code and shadow-slot definitions for the
// ID-side hazard/forwarding controller and the EX stage that consumes its codes.
package hazard_fwd_ctrl_pkg;

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_ADD = 6'h01;
   localparam logic [5:0] OP_SUB = 6'h02;
   localparam logic [5:0] OP_LDW = 6'h23;
   localparam logic [5:0] OP_SDW = 6'h2b;

   localparam logic [2:0] FWD_NONE  = 3'd0;
   localparam logic [2:0] FWD_EX    = 3'd1;
   localparam logic [2:0] FWD_MEM   = 3'd2;
   localparam logic [2:0] LDFWD_MEM = 3'd2;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rwd;
      logic       vld;
   } slot_t;

   // Stores and NOPs occupy a slot but never write the regfile.
   function automatic logic is_writer(input slot_t s);
      return s.vld && (s.rwd != 5'd0) && (s.op != OP_SDW) && (s.op != OP_NOP);
   endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_src_check.sv
// Hazard check for one source register against the EX (age 1) and MEM (age 2)
// shadow slots; youngest producer wins.
module hazard_src_check
   import hazard_fwd_ctrl_pkg::*;
(
   input  logic [4:0] i_src,
   input  slot_t      i_ex,
   input  slot_t      i_mem,
   input  logic       i_is_store_data,
   output logic [2:0] o_fwd_code,
   output logic [2:0] o_ld_code,
   output logic       o_stall_req
);

   logic w_a1;
   logic w_a2;

   assign w_a1 = is_writer(i_ex)  && (i_ex.rwd  == i_src) && (i_src != 5'd0);
   assign w_a2 = is_writer(i_mem) && (i_mem.rwd == i_src) && (i_src != 5'd0);

   always_comb begin
      o_fwd_code  = FWD_NONE;
      o_ld_code   = FWD_NONE;
      o_stall_req = 1'b0;
      if (i_is_store_data) begin
         // EX has no forwarding path for store data: wait until WB write-through.
         o_stall_req = w_a1 | w_a2;
      end else if (w_a1) begin
         if (i_ex.op == OP_LDW) o_stall_req = 1'b1;
         else                   o_fwd_code  = FWD_EX;
      end else if (w_a2) begin
         if (i_mem.op == OP_LDW) o_ld_code  = LDFWD_MEM;
         else                    o_fwd_code = FWD_MEM;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID-side hazard detection and EX operand-forwarding control. Forwarding codes
// are registered so they arrive in EX with the instruction; stall is combinational.
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [5:0]             id_opcode,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic [4:0]             id_rwd,
   output logic [2:0]             rs_fwd,
   output logic [2:0]             rt_fwd,
   output logic [2:0]             ld_rs_fwd,
   output logic [2:0]             ld_rt_fwd,
   output logic                   stall,
   output logic [STALL_CNT_W-1:0] stall_count
);

   slot_t r_ex;
   slot_t r_mem;
   logic [2:0] r_rs_fwd, r_rt_fwd, r_ld_rs_fwd, r_ld_rt_fwd;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic       w_is_ldw, w_is_sdw, w_is_mem;
   logic [2:0] w_rs_code, w_rs_ld, w_rt_code, w_rt_ld;
   logic       w_rs_stall, w_rt_stall, w_rt_stall_eff;
   logic [2:0] w_rs_fwd, w_rt_fwd, w_ld_rs_fwd, w_ld_rt_fwd;
   logic       w_stall;

   assign w_is_ldw = (id_opcode == OP_LDW);
   assign w_is_sdw = (id_opcode == OP_SDW);
   assign w_is_mem = w_is_ldw | w_is_sdw;

   hazard_src_check u_rs_chk (
      .i_src           (id_rs),
      .i_ex            (r_ex),
      .i_mem           (r_mem),
      .i_is_store_data (1'b0),
      .o_fwd_code      (w_rs_code),
      .o_ld_code       (w_rs_ld),
      .o_stall_req     (w_rs_stall)
   );

   hazard_src_check u_rt_chk (
      .i_src           (id_rt),
      .i_ex            (r_ex),
      .i_mem           (r_mem),
      .i_is_store_data (w_is_sdw),
      .o_fwd_code      (w_rt_code),
      .o_ld_code       (w_rt_ld),
      .o_stall_req     (w_rt_stall)
   );

   // Loads take imm as operand b, so their rt is not a source at all.
   assign w_rt_stall_eff = w_is_ldw ? 1'b0 : w_rt_stall;
   assign w_stall        = id_valid & (w_rs_stall | w_rt_stall_eff);
   assign stall          = w_stall;

   assign w_rs_fwd    = id_valid ? w_rs_code : FWD_NONE;
   assign w_ld_rs_fwd = id_valid ? w_rs_ld   : FWD_NONE;
   // A nonzero rt_fwd would override imm in EX for memory ops.
   assign w_rt_fwd    = (id_valid && !w_is_mem) ? w_rt_code : FWD_NONE;
   assign w_ld_rt_fwd = (id_valid && !w_is_mem) ? w_rt_ld   : FWD_NONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_rs_fwd    <= FWD_NONE;
         r_rt_fwd    <= FWD_NONE;
         r_ld_rs_fwd <= FWD_NONE;
         r_ld_rt_fwd <= FWD_NONE;
         r_stall_cnt <= '0;
      end else begin
         r_mem <= r_ex;
         if (w_stall) begin
            r_ex        <= '0;
            r_rs_fwd    <= FWD_NONE;
            r_rt_fwd    <= FWD_NONE;
            r_ld_rs_fwd <= FWD_NONE;
            r_ld_rt_fwd <= FWD_NONE;
         end else begin
            r_ex        <= '{op: id_opcode, rwd: id_rwd, vld: id_valid};
            r_rs_fwd    <= w_rs_fwd;
            r_rt_fwd    <= w_rt_fwd;
            r_ld_rs_fwd <= w_ld_rs_fwd;
            r_ld_rt_fwd <= w_ld_rt_fwd;
         end
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign rs_fwd      = r_rs_fwd;
   assign rt_fwd      = r_rt_fwd;
   assign ld_rs_fwd   = r_ld_rs_fwd;
   assign ld_rt_fwd   = r_ld_rt_fwd;
   assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for hazard_fwd_ctrl: each issued ID cycle queues the
// hand-derived outputs expected at that cycle's negedge; a monitor compares them.
module tb_hazard_fwd_ctrl;
   import hazard_fwd_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [5:0]  id_opcode = OP_NOP;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rwd = '0;
   logic [2:0]  rs_fwd, rt_fwd, ld_rs_fwd, ld_rt_fwd;
   logic        stall;
   logic [15:0] stall_count;

   hazard_fwd_ctrl #(.STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rwd(id_rwd),
      .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .ld_rs_fwd(ld_rs_fwd), .ld_rt_fwd(ld_rt_fwd),
      .stall(stall), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      logic [28:0] v;   // {stall, rs, rt, ld_rs, ld_rt, count}
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic logic [28:0] act_vec();
      return {stall, rs_fwd, rt_fwd, ld_rs_fwd, ld_rt_fwd, stall_count};
   endfunction

   task automatic cmp(input string name, input logic [28:0] act, input logic [28:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got stall=%0b rs=%0d rt=%0d lrs=%0d lrt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d lrs=%0d lrt=%0d cnt=%0d",
                  name, act[28], act[27:25], act[24:22], act[21:19], act[18:16], act[15:0],
                  exp[28], exp[27:25], exp[24:22], exp[21:19], exp[18:16], exp[15:0]);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp($sformatf("cycle%0d", e.tag), act_vec(), e.v);
      end
   end

   int tag = 0;
   task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rwd,
                        input logic es, input logic [2:0] ers, ert, elrs, elrt,
                        input logic [15:0] ecnt);
      exp_t e;
      @(posedge clk); #1;
      id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rwd = rwd;
      e.tag = tag; e.v = {es, ers, ert, elrs, elrt, ecnt};
      q.push_back(e);
      tag++;
   endtask

   task automatic bubble(input logic [2:0] ers, ert, elrs, elrt, input logic [15:0] ecnt);
      issue(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, ers, ert, elrs, elrt, ecnt);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      cmp("reset_state", act_vec(), 29'd0);
      rst = 1'b0;

      // c0..c3: add r3 ; add r4,r3,r1 -> rs_fwd = 1
      bubble(0,0,0,0,0);
      issue(1, OP_ADD, 1, 2, 3,  0, 0,0,0,0, 0);
      issue(1, OP_ADD, 3, 1, 4,  0, 0,0,0,0, 0);
      bubble(1,0,0,0,0);
      // c4..c7: add r3 ; nop ; sub r5,r3,r3 -> rs=rt=2
      issue(1, OP_ADD, 1, 2, 3,  0, 0,0,0,0, 0);
      issue(1, OP_NOP, 0, 0, 0,  0, 0,0,0,0, 0);
      issue(1, OP_SUB, 3, 3, 5,  0, 0,0,0,0, 0);
      bubble(2,2,0,0,0);
      // c8..c11: ldw r2 ; add r6,r2,r7 -> one stall, then ld_rs = 2
      issue(1, OP_LDW, 1, 0, 2,  0, 0,0,0,0, 0);
      issue(1, OP_ADD, 2, 7, 6,  1, 0,0,0,0, 0);
      issue(1, OP_ADD, 2, 7, 6,  0, 0,0,0,0, 1);
      bubble(0,0,2,0,1);
      // c12..c16: add r9 ; sdw data r9 base r1 -> two stalls
      issue(1, OP_ADD, 1, 2, 9,  0, 0,0,0,0, 1);
      issue(1, OP_SDW, 1, 9, 0,  1, 0,0,0,0, 1);
      issue(1, OP_SDW, 1, 9, 0,  1, 0,0,0,0, 2);
      issue(1, OP_SDW, 1, 9, 0,  0, 0,0,0,0, 3);
      bubble(0,0,0,0,3);
      // c17..c19: ldw whose rt hits an age-1 ALU writer: no stall, rt codes 0
      issue(1, OP_ADD, 1, 2, 10, 0, 0,0,0,0, 3);
      issue(1, OP_LDW, 1, 10, 11, 0, 0,0,0,0, 3);
      bubble(0,0,0,0,3);
      // c20..c26: r0 writers/loads never forward or stall; invalid consumer never stalls
      issue(1, OP_ADD, 1, 2, 0,  0, 0,0,0,0, 3);
      issue(1, OP_ADD, 0, 0, 5,  0, 0,0,0,0, 3);
      issue(1, OP_LDW, 1, 0, 0,  0, 0,0,0,0, 3);
      issue(1, OP_ADD, 0, 0, 6,  0, 0,0,0,0, 3);
      issue(1, OP_LDW, 1, 0, 8,  0, 0,0,0,0, 3);
      issue(0, OP_ADD, 8, 8, 7,  0, 0,0,0,0, 3);
      bubble(0,0,0,0,3);
      // c27..c28: load-use stall, then reset in the middle of it
      issue(1, OP_LDW, 1, 0, 2,  0, 0,0,0,0, 3);
      issue(1, OP_ADD, 2, 7, 6,  1, 0,0,0,0, 3);
      @(negedge clk); #1;
      rst = 1'b1;
      #1 cmp("reset_mid_stall", act_vec(), 29'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 cmp("after_release", act_vec(), 29'd0);
      // counter restarts from 0
      bubble(0,0,0,0,0);
      issue(1, OP_LDW, 1, 0, 2,  0, 0,0,0,0, 0);
      issue(1, OP_ADD, 2, 7, 6,  1, 0,0,0,0, 0);
      issue(1, OP_ADD, 2, 7, 6,  0, 0,0,0,0, 1);
      bubble(0,0,2,0,1);

      // drain the scoreboard before the long forced stall
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
         q.delete();
      end

      @(negedge clk);
      id_valid = 1'b0;
      force dut.w_stall = 1'b1;
      repeat (70000) @(posedge clk);
      @(negedge clk); #1;
      n_chk++;
      if (stall_count !== 16'hffff) begin
         n_fail++;
         $display("FAIL saturate: got %0d, want 65535", stall_count);
      end
      release dut.w_stall;
      @(negedge clk); #1;
      n_chk++;
      if (stall !== 1'b0 || stall_count !== 16'hffff) begin
         n_fail++;
         $display("FAIL post_release: got stall=%0b cnt=%0d, want stall=0 cnt=65535", stall, stall_count);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
